// File: rtl/dma_route_demux.sv
`default_nettype none
// ============================================================================
// Module   : dma_route_demux
// Purpose  : Steers DMA payloads into per-channel FIFOs using a reversed
//            low-order address map, counting out-of-range words as drops.
// Options  : DMA_ROUTE_BCAST_EN - all-ones address broadcasts to every channel.
// Revision : 1.0 - initial release
// ============================================================================
module dma_route_demux #(
    parameter int NUM_CH     = 18,
    parameter int WORD_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 25,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        in_word,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [15:0]              err_cnt,
    output logic                     err_flag
);

    localparam int                  c_idx_w   = $clog2(FIFO_DEPTH);
    localparam int                  c_ptr_w   = c_idx_w + 1;
    localparam logic [ADDR_W-1:0]   c_num_ch  = ADDR_W'(NUM_CH);
    localparam logic [c_ptr_w-1:0]  c_ptr_one = {{c_idx_w{1'b0}}, 1'b1};

    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_payload;
    logic              w_unused_bits;
    logic              w_in_range;
    logic              w_bcast;
    logic              w_target_full;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drop;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_push;

    logic [15:0]       r_err_cnt;
    logic              r_err_flag;

    assign w_addr        = in_word[ADDR_W-1:0];
    assign w_payload     = in_word[WORD_W-1 -: DATA_W];
    assign w_unused_bits = ^in_word;
    assign w_in_range    = (w_addr < c_num_ch);

`ifdef DMA_ROUTE_BCAST_EN
    assign w_bcast = (w_addr == {ADDR_W{1'b1}});
`else
    assign w_bcast = 1'b0;
`endif

    // Ready depends only on address and full flags, never on out_ready.
    assign w_target_full = |(w_sel & w_full);

    always_comb begin
        w_in_ready = 1'b1;
        if (w_bcast) begin
            w_in_ready = ~|w_full;
        end else if (w_in_range) begin
            w_in_ready = ~w_target_full;
        end
    end

    assign in_ready = w_in_ready;
    assign w_accept = in_valid & w_in_ready & ~rst;
    assign w_drop   = w_accept & ~w_in_range & ~w_bcast;
    assign w_push   = w_accept ? (w_bcast ? {NUM_CH{1'b1}} : w_sel) : {NUM_CH{1'b0}};

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            localparam logic [ADDR_W-1:0] c_ch_addr = ADDR_W'(NUM_CH - 1 - c);

            logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
            logic [c_ptr_w-1:0] r_wptr;
            logic [c_ptr_w-1:0] r_rptr;
            logic               w_pop;

            assign w_sel[c]   = w_in_range & (w_addr == c_ch_addr);
            assign w_empty[c] = (r_wptr == r_rptr);
            // Same index with differing wrap bits means the writer lapped the reader.
            assign w_full[c]  = (r_wptr[c_idx_w] != r_rptr[c_idx_w]) &&
                                (r_wptr[c_idx_w-1:0] == r_rptr[c_idx_w-1:0]);
            assign w_pop      = out_ready[c] & ~w_empty[c];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wptr <= '0;
                    r_rptr <= '0;
                end else begin
                    if (w_push[c]) begin
                        r_wptr <= r_wptr + c_ptr_one;
                    end
                    if (w_pop) begin
                        r_rptr <= r_rptr + c_ptr_one;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[c]) begin
                    r_mem[r_wptr[c_idx_w-1:0]] <= w_payload;
                end
            end

            assign out_valid[c]                  = ~w_empty[c];
            assign out_data[c*DATA_W +: DATA_W] = w_empty[c] ? {DATA_W{1'b0}}
                                                             : r_mem[r_rptr[c_idx_w-1:0]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt  <= '0;
            r_err_flag <= 1'b0;
        end else if (w_drop) begin
            if (r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
            r_err_flag <= 1'b1;
        end
    end

    assign err_cnt  = r_err_cnt;
    assign err_flag = r_err_flag;

endmodule
`default_nettype wire

// File: tb/tb_dma_route_demux.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_route_demux
// Purpose  : Randomised scoreboard bench for dma_route_demux against a
//            queue-based channel model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_route_demux;

    localparam int NUM_CH = 18;
    localparam int WORD_W = 32;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 25;
    localparam int DEPTH  = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [WORD_W-1:0]        in_word = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic [NUM_CH-1:0]        out_ready = '0;
    logic [15:0]              err_cnt;
    logic                     err_flag;

    always #5 clk = ~clk;

    dma_route_demux #(
        .NUM_CH(NUM_CH), .WORD_W(WORD_W), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .in_word(in_word), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .err_cnt(err_cnt), .err_flag(err_flag)
    );

    int                tests = 0;
    int                fails = 0;
    logic [DATA_W-1:0] exp_q [NUM_CH][$];
    bit   [NUM_CH-1:0] pop_now = '0;
    int                exp_err = 0;
    bit                exp_flag = 1'b0;
    bit                armed = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk(input logic [DATA_W-1:0] p, input int a);
        logic [ADDR_W-1:0] av;
        av = ADDR_W'(a);
        return {p, 2'b00, av};
    endfunction

    // Monitor: compares every channel head against the scoreboard and retires pops.
    always @(negedge clk) begin
        #1;
        pop_now = '0;
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                check("out_valid", 64'(out_valid[c]), 64'(exp_q[c].size() != 0));
                if (exp_q[c].size() == 0) begin
                    check("empty_data", 64'(out_data[c*DATA_W +: DATA_W]), 64'd0);
                end else if (out_ready[c]) begin
                    check("pop_data", 64'(out_data[c*DATA_W +: DATA_W]), 64'(exp_q[c][0]));
                    void'(exp_q[c].pop_front());
                    pop_now[c] = 1'b1;
                end
            end
        end
    end

    // Driver: one cycle of stimulus, predicted ready, and scoreboard push.
    task automatic step(input bit v, input logic [WORD_W-1:0] w,
                        input logic [NUM_CH-1:0] rdy, input bit r);
        int  a;
        bit  er;
        bit  bc;
        @(negedge clk);
        if (armed) begin
            check("err_cnt", 64'(err_cnt), 64'(exp_err));
            check("err_flag", 64'(err_flag), 64'(exp_flag));
        end
        rst       = r;
        in_valid  = v;
        in_word   = w;
        out_ready = rdy;
        #2;
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) exp_q[c].delete();
            exp_err  = 0;
            exp_flag = 1'b0;
            armed    = 1'b1;
        end else begin
            a  = int'(w[ADDR_W-1:0]);
            bc = 1'b0;
`ifdef DMA_ROUTE_BCAST_EN
            bc = (a == (1 << ADDR_W) - 1);
`endif
            if (bc) begin
                er = 1'b1;
                for (int c = 0; c < NUM_CH; c++)
                    if (exp_q[c].size() + int'(pop_now[c]) >= DEPTH) er = 1'b0;
            end else if (a < NUM_CH) begin
                er = (exp_q[NUM_CH-1-a].size() + int'(pop_now[NUM_CH-1-a]) < DEPTH);
            end else begin
                er = 1'b1;
            end
            check("in_ready", 64'(in_ready), 64'(er));
            if (v && er) begin
                if (bc) begin
                    for (int c = 0; c < NUM_CH; c++) exp_q[c].push_back(w[WORD_W-1 -: DATA_W]);
                end else if (a < NUM_CH) begin
                    exp_q[NUM_CH-1-a].push_back(w[WORD_W-1 -: DATA_W]);
                end else begin
                    if (exp_err < 16'hFFFF) exp_err++;
                    exp_flag = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] rmask;
        int                a;

        step(0, '0, '0, 1);
        step(0, '0, '0, 1);
        step(0, '0, '0, 0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_data", 64'(|out_data), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);

        // Address 0 lands on the highest channel.
        step(1, mk(25'h1ABCDEF, 0), '0, 0);
        step(0, '0, '0, 0);
        check("addr0_valid", 64'(out_valid), 64'h20000);
        check("addr0_data", 64'(out_data[17*DATA_W +: DATA_W]), 64'h1ABCDEF);
        step(0, '0, '1, 0);

        // Fill channel 14 via address 3, then release it.
        for (int i = 0; i < 5; i++) step(1, mk(25'(i + 16'h100), 3), '0, 0);
        check("full_ready", 64'(in_ready), 64'd0);
        rmask = '0;
        rmask[14] = 1'b1;
        step(1, mk(25'h1FF, 3), rmask, 0);
        step(1, mk(25'h1FE, 3), rmask, 0);
        check("ready_back", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) step(0, '0, '1, 0);

        // Out-of-range words are accepted and counted.
        step(1, mk(25'h11, 18), '0, 0);
        step(1, mk(25'h12, 30), '0, 0);
        step(1, mk(25'h13, 31), '0, 0);
        step(0, '0, '0, 0);
`ifndef DMA_ROUTE_BCAST_EN
        check("err_cnt3", 64'(err_cnt), 64'd3);
        check("err_flag1", 64'(err_flag), 64'd1);
        check("err_novalid", 64'(out_valid), 64'd0);
`endif

        // Occupancy 2 under continuous push+pop across pointer wrap.
        rmask = '0;
        rmask[12] = 1'b1;
        step(1, mk(25'h200, 5), '0, 0);
        step(1, mk(25'h201, 5), '0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, mk(25'(16'h300 + i), 5), rmask, 0);
            check("occ2_ready", 64'(in_ready), 64'd1);
        end
        for (int i = 0; i < 4; i++) step(0, '0, '1, 0);

`ifdef DMA_ROUTE_BCAST_EN
        step(0, '0, '0, 1);
        step(1, mk(25'h5, 31), '0, 0);
        step(0, '0, '0, 0);
        check("bcast_valid", 64'(out_valid), 64'h3FFFF);
        check("bcast_data0", 64'(out_data[0 +: DATA_W]), 64'h5);
        check("bcast_err", 64'(err_cnt), 64'd0);
        for (int i = 0; i < 3; i++) step(1, mk(25'(i), 17), '0, 0);
        step(1, mk(25'h6, 31), '0, 0);
        check("bcast_full", 64'(in_ready), 64'd0);
        for (int i = 0; i < 5; i++) step(0, '0, '1, 0);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ((i / 200) % 2 == 0) a = int'($urandom_range(0, 5));
            else a = int'($urandom_range(0, 31));
            rmask = NUM_CH'($urandom()) & NUM_CH'($urandom());
            if ($urandom_range(0, 7) == 0) rmask = '1;
            step($urandom_range(0, 3) != 0, mk(25'($urandom()), a), rmask,
                 $urandom_range(0, 499) == 0);
        end

        // Reset with buffered data and a non-zero error count.
        step(0, '0, '0, 1);
        for (int i = 0; i < 7; i++) step(1, mk(25'(i), 20), '0, 0);
        for (int i = 0; i < 3; i++) step(1, mk(25'(i + 1), 2), '0, 0);
        step(0, '0, '0, 0);
        check("pre_rst_err", 64'(err_cnt), 64'd7);
        step(1, mk(25'h7, 2), '1, 1);
        step(0, '0, '0, 0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(|out_data), 64'd0);
        check("rst_err", 64'(err_cnt), 64'd0);
        check("rst_flag", 64'(err_flag), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        step(0, '0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
